// File: rtl/edge_log_stream.sv
// rtl/edge_log_stream.sv - streaming 5x5 Laplacian-of-Gaussian edge stage
// Raster pixel stream in, one saturated filtered pixel out per interior window position.
`timescale 1ns/1ps
module edge_log_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last
);
  localparam int SW = PIX_W + 7;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [SW:0] SAT_LIM = {{(SW+1-PIX_W){1'b0}}, {PIX_W{1'b1}}};
  localparam int KERN [25] = '{-1, -3, -4, -3, -1,
                               -3,  0,  6,  0, -3,
                               -4,  6, 20,  6, -4,
                               -3,  0,  6,  0, -3,
                               -1, -3, -4, -3, -1};

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [1:0]       mode_q, mode_d, frame_mode;
  logic             en, accept, first_px, last_px, win_done;

  logic [PIX_W-1:0] lb_q  [4][IMG_W];
  logic [PIX_W-1:0] win_q [5][5];

  logic             v1_q, last1_q;
  logic [1:0]       mode1_q;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [PIX_W-1:0] ctr2_q;
  logic [1:0]       mode2_q;
  logic             v2_q, last2_q;
  logic             v3_q, last3_q;
  logic [PIX_W-1:0] data3_q, data3_d;
  int               acc;
  logic [SW-1:0]    abs_v, mag;
  logic [SW:0]      enh;

  assign en       = !v3_q || m_ready;
  assign s_ready  = en;
  assign accept   = s_valid && en;
  assign first_px = (col_q == '0) && (row_q == '0);
  assign last_px  = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));
  assign win_done = accept && (col_q >= CW'(4)) && (row_q >= RW'(4));
  // The frame's mode is taken live on pixel (0,0) and held in mode_q for the rest.
  assign frame_mode = first_px ? mode : mode_q;

  assign m_valid = v3_q;
  assign m_data  = data3_q;
  assign m_last  = last3_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    if (accept) begin
      mode_d = frame_mode;
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        acc = acc + KERN[i*5+j] * int'(win_q[i][j]);
      end
    end
    sum_d = SW'(acc);
  end

  always_comb begin
    abs_v = sum_q[SW-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
    mag   = abs_v >> 4;
    enh   = {1'b0, mag} + {{(SW+1-PIX_W){1'b0}}, ctr2_q};
    case (mode2_q)
      2'd0:    data3_d = (enh > SAT_LIM) ? {PIX_W{1'b1}} : enh[PIX_W-1:0];
      2'd1:    data3_d = ({1'b0, mag} > SAT_LIM) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
      default: data3_d = ctr2_q;
    endcase
  end

  // Line buffers hold rows r-4..r-1 at each column; the new column enters window column 4.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[3][col_q] <= s_data;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
      end
      for (int i = 0; i < 4; i++) begin
        win_q[i][4] <= lb_q[i][col_q];
      end
      win_q[4][4] <= s_data;
    end
    if (en) begin
      sum_q   <= sum_d;
      ctr2_q  <= win_q[2][2];
      mode2_q <= mode1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      mode1_q <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      data3_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      if (en) begin
        v1_q    <= win_done;
        last1_q <= win_done && last_px;
        mode1_q <= frame_mode;
        v2_q    <= v1_q;
        last2_q <= last1_q;
        v3_q    <= v2_q;
        last3_q <= last2_q;
        if (v2_q) begin
          data3_q <= data3_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_edge_log_stream.sv
// tb/tb_edge_log_stream.sv - directed self-checking bench for edge_log_stream
// Small 9x9 frames; expected pixels come from hand values and a direct convolution model.
`timescale 1ns/1ps
module tb_edge_log_stream;
  localparam int PW = 8;
  localparam int W  = 9;
  localparam int H  = 9;
  localparam int KERN [25] = '{-1, -3, -4, -3, -1,
                               -3,  0,  6,  0, -3,
                               -4,  6, 20,  6, -4,
                               -3,  0,  6,  0, -3,
                               -1, -3, -4, -3, -1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [PW-1:0] m_data;
  logic          m_last;

  int checks = 0;
  int failures = 0;
  int img [H][W];
  int out_d [$];
  int out_l [$];
  int stall_cyc = 0;
  int bp_viol = 0;
  int push_stalls = 0;
  bit rand_ready = 1'b0;
  bit held = 1'b0;
  logic [PW:0] held_v;

  edge_log_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      out_d.push_back(int'(m_data));
      out_l.push_back(int'(m_last));
    end
    if (!rst && m_valid && !m_ready) begin
      stall_cyc++;
      if (s_ready) bp_viol++;
      if (held && {m_last, m_data} != held_v) bp_viol++;
      held = 1'b1;
      held_v = {m_last, m_data};
    end else begin
      held = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  function automatic int ref_out(input int c, input int r, input int m);
    int s = 0;
    int mg, ctr;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s += KERN[i*5+j] * img[r-2+i][c-2+j];
    mg  = (s < 0 ? -s : s) >> 4;
    ctr = img[r][c];
    if (m == 0) return (mg + ctr > 255) ? 255 : mg + ctr;
    if (m == 1) return (mg > 255) ? 255 : mg;
    return ctr;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 0) ? 100 : (kind == 1) ? ((r == 4 && c == 4) ? 255 : 0) : c + r;
  endtask

  task automatic push(input int px);
    int n = 0;
    s_valid = 1'b1;
    s_data  = PW'(px);
    @(negedge clk);
    while (!s_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    push_stalls += n;
    @(posedge clk);
    #1;
  endtask

  // m < 0 leaves the mode input as it is.
  task automatic send_frame(input int m, input bit chg);
    if (m >= 0) mode = 2'(m);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (chg && r == 5 && c == 3) mode = 2'd0;
        push(img[r][c]);
      end
  endtask

  task automatic drain(input int n, input string tag);
    int t = 0;
    s_valid = 1'b0;
    while (out_d.size() < n && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, out_d.size(), n);
  endtask

  task automatic check_frame(input int m, input int base, input string tag);
    for (int k = 0; k < 25 && base + k < out_d.size(); k++) begin
      check($sformatf("%s_px%0d", tag, k), out_d[base+k], ref_out(2 + k % 5, 2 + k / 5, m));
      check($sformatf("%s_last%0d", tag, k), out_l[base+k], (k == 24) ? 1 : 0);
    end
  endtask

  task automatic clear_out();
    out_d.delete();
    out_l.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    rst = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);

    fill(0);
    send_frame(0, 0);
    drain(25, "flat0");
    check_frame(0, 0, "flat0");
    if (out_d.size() > 12) check("flat0_hand", out_d[12], 100);
    clear_out();
    send_frame(1, 0);
    drain(25, "flat1");
    check_frame(1, 0, "flat1");
    if (out_d.size() > 0) check("flat1_hand", out_d[0], 0);
    clear_out();

    fill(1);
    send_frame(1, 0);
    drain(25, "imp1");
    check_frame(1, 0, "imp1");
    if (out_d.size() == 25) begin
      check("imp1_c44", out_d[12], 255);
      check("imp1_c22", out_d[0], 15);
      check("imp1_c42", out_d[2], 63);
    end
    clear_out();
    send_frame(0, 0);
    drain(25, "imp0");
    if (out_d.size() == 25) check("imp0_c44", out_d[12], 255);
    clear_out();

    rand_ready = 1'b1;
    send_frame(1, 0);
    drain(25, "bp");
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    check_frame(1, 0, "bp");
    check("bp_violations", bp_viol, 0);
    check("bp_stalled", (stall_cyc > 0) ? 1 : 0, 1);
    clear_out();

    fill(2);
    send_frame(2, 1);
    drain(25, "ramp2");
    check_frame(2, 0, "ramp2");
    if (out_d.size() > 6) check("ramp2_hand", out_d[6], 6);
    clear_out();
    fill(1);
    send_frame(-1, 0);
    drain(25, "latch0");
    check_frame(0, 0, "latch0");
    if (out_d.size() > 0) check("latch0_c22", out_d[0], 15);
    clear_out();

    fill(0);
    mode = 2'd0;
    for (int i = 0; i < 30; i++) push(100);
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst1_m_valid", m_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 42; i++) push(100);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_pre_valid", m_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst2_m_valid", m_valid, 0);
    check("rst2_m_last", m_last, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_out();
    send_frame(0, 0);
    drain(25, "rstfresh");
    check_frame(0, 0, "rstfresh");
    clear_out();

    push_stalls = 0;
    send_frame(0, 0);
    send_frame(0, 0);
    check("tput_stalls", push_stalls, 0);
    drain(50, "tput");
    check_frame(0, 0, "tput_f0");
    check_frame(0, 25, "tput_f1");
    begin
      int nl = 0;
      foreach (out_l[k]) nl += out_l[k];
      check("tput_nlast", nl, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edge_log_stream.md
# edge_log_stream

Streaming, parametrised successor to the combinational 5x5 Laplacian-of-Gaussian edge stage. It accepts a raster-order pixel stream over valid/ready, keeps four line buffers plus a 5x5 window, and emits one filtered pixel per interior window position. The output is either the edge-enhanced pixel, the edge magnitude alone, or the centre pixel unchanged, and results saturate instead of truncating. It sits between the decoder's pixel output and the frame writer.

## Interface
- PIX_W, 8, pixel width in bits
- IMG_W, 640, frame width in pixels (≥5)
- IMG_H, 480, frame height in lines (≥5)
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0 = enhance, 1 = magnitude, 2/3 = passthrough; sampled per frame
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  PIX_W  input pixel, unsigned, raster order
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  PIX_W  filtered pixel
- m_last  out  1  high with the final output pixel of a frame

## Operation
- **Kernel.** Rows top to bottom, columns left to right. Centre is window position (2,2).
  - Row 0: -1 -3 -4 -3 -1
  - Row 1: -3 0 6 0 -3
  - Row 2: -4 6 20 6 -4
  - Row 3: -3 0 6 0 -3
  - Row 4: -1 -3 -4 -3 -1
- **Counters.** col counts 0..IMG_W-1 and row counts 0..IMG_H-1 on each accepted pixel. Both wrap to 0 after pixel (IMG_W-1, IMG_H-1); the next accepted pixel starts a new frame.
- **Mode latch.** mode is latched when pixel (0,0) is accepted. Changes to mode mid-frame have no effect until the next frame.
- **Line buffers.** Four buffers of IMG_W x PIX_W each. The window shifts left one column per accepted pixel.
- **Output generation.** An accepted pixel at (c,r) with c≥4 and r≥4 completes the window centred on (c-2, r-2) and produces one output. All other pixels produce none. Each frame emits exactly (IMG_W-4)*(IMG_H-4) outputs. Borders are dropped, and windows never span row boundaries.
- **Arithmetic.**
  - sum is signed, PIX_W+7 bits; the range is ±44*(2^PIX_W-1), so it never overflows.
  - mag = |sum| >> 4.
  - Mode 0: m_data = min(mag + centre, 2^PIX_W-1).
  - Mode 1: m_data = min(mag, 2^PIX_W-1).
  - Mode 2/3: m_data = centre.
- **m_last.** Asserted with the output for centre (IMG_W-3, IMG_H-3).
- **Reset.**
  - All outputs reset to 0: m_valid=0, m_data=0, m_last=0. The latched mode resets to 0.
  - Counters and pipeline valid bits reset to 0.
  - Line buffer and window contents are not cleared; they are overwritten before use.
  - A reset asserted mid-frame discards the partial frame. The first pixel after reset is pixel (0,0).

## Timing
- **Pipeline.** Three stages:
  - S1: window/line-buffer update on the accept edge.
  - S2: registered sum.
  - S3: registered saturate/select into m_data.
- **Enable.** en = !m_valid || m_ready. s_ready = en, combinational.
- All stages advance only when en=1. Bubbles (s_valid=0) propagate as invalid slots.
- **Latency.** A pixel accepted at edge k with no stall: its output has m_valid=1 after edge k+2.
- **Throughput.** One pixel per cycle when s_valid=1 and m_ready=1 continuously.
- **Backpressure.** While m_valid=1 and m_ready=0, m_data, m_last and m_valid hold stable and no pixel is accepted.
- **Back-to-back frames.** Pixel (0,0) of frame N+1 may be accepted on the cycle after the last pixel of frame N. No gap is required.

## Test plan
- **Flat frame.** IMG_W=IMG_H=9, all pixels 100. Mode 0 → 25 outputs of 100. Mode 1 → 25 outputs of 0. m_last only on output 25.
- **Impulse.** IMG_W=IMG_H=9, 255 at (4,4), zeros elsewhere, mode 1.
  - Output centre (4,4) = 255 (saturated from 318).
  - Output centre (2,2) = 15.
  - Output centre (4,2) = 63 (coefficient -4).
  - Mode 0 at centre (4,4) = 255.
- **Passthrough and mode latching.** Ramp frame with pixel = c+r. Mode 2 → output for centre (c,r) equals c+r. Changing mode to 0 at pixel (3,5) does not alter the current frame; the next frame is in mode 0.
- **Backpressure.** Random m_ready (50%) with continuous s_valid on the impulse frame.
  - Output sequence identical to the unstalled run.
  - s_ready low whenever m_valid && !m_ready.
  - m_data stable while stalled.
- **Reset mid-frame.** Assert rst after 30 pixels of a flat-100 frame.
  - m_valid and m_last drop to 0 immediately, without waiting for a clock edge.
  - A full fresh frame afterwards yields exactly 25 correct outputs.
- **Throughput.** Two back-to-back 9x9 frames, m_ready=1. 50 outputs, m_last at outputs 25 and 50, no accept stalls.
